// File: rtl/result_stream_out.sv
// Result FIFO plus raster re-emitter: buffers one window result per cycle and
// streams it out with valid/ready and sof/eol/eof markers on the held pixel.
module result_stream_out #(
    parameter int IMG_WIDTH   = 480,
    parameter int OUT_ROWS    = 475,
    parameter int BORDER_COLS = 5,
    parameter int FIFO_DEPTH  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  result,
    input  logic        result_valid,
    output logic [7:0]  pixel_out,
    output logic        pixel_out_valid,
    input  logic        pixel_out_ready,
    output logic        sof,
    output logic        eol,
    output logic        eof,
    output logic [10:0] fifo_level,
    output logic        overflow,
    output logic [15:0] frame_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST     = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] BORDER_START = CW'(IMG_WIDTH - BORDER_COLS);
    localparam logic [RW-1:0] ROW_LAST     = RW'(OUT_ROWS - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0] in_col, out_col;
    logic [RW-1:0] out_row;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [7:0]    wdata, s1_data;
    logic          s1_valid;
    logic          full, empty, wr_en, pop, load, ld_pix, xfer, frame_done;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en      = result_valid && !full;
    assign xfer       = pixel_out_valid && pixel_out_ready;
    assign load       = !pixel_out_valid || xfer;
    assign ld_pix     = load && s1_valid;
    assign pop        = !empty && (!s1_valid || load);
    assign wdata      = (in_col >= BORDER_START) ? 8'h00 : result;
    assign fifo_level = 11'(wr_ptr - rd_ptr);

    // Column keeps advancing on dropped writes so the raster stays aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_col   <= '0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else if (result_valid) begin
            in_col <= (in_col == COL_LAST) ? '0 : in_col + 1'b1;
            if (full) overflow <= 1'b1;
            else      wr_ptr   <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Registered read stage between the memory and the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            s1_data  <= 8'h00;
            s1_valid <= 1'b0;
        end else if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            s1_data  <= mem[rd_ptr[AW-1:0]];
            s1_valid <= 1'b1;
        end else if (load) begin
            s1_valid <= 1'b0;
        end
    end

    // out_col/out_row give the raster position of the next pixel to load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_out_valid <= 1'b0;
            pixel_out       <= 8'h00;
            sof             <= 1'b0;
            eol             <= 1'b0;
            eof             <= 1'b0;
            out_col         <= '0;
            out_row         <= '0;
        end else if (load) begin
            pixel_out_valid <= s1_valid;
            pixel_out       <= s1_valid ? s1_data : 8'h00;
            sof             <= s1_valid && (out_col == '0) && (out_row == '0);
            eol             <= s1_valid && (out_col == COL_LAST);
            eof             <= s1_valid && (out_col == COL_LAST) && (out_row == ROW_LAST);
            if (s1_valid) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ld_pix) state_d = STREAM;
            STREAM:  if (xfer && eof) state_d = DONE;
            DONE:    state_d = (ld_pix || (pixel_out_valid && !xfer)) ? STREAM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_done = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           frame_count <= 16'd0;
        else if (frame_done) frame_count <= frame_count + 16'd1;
    end
endmodule

// File: tb/tb_result_stream_out.sv
// Directed bench for result_stream_out with a short 3-row frame so a full
// frame fits comfortably in simulation time.
module tb_result_stream_out;
    localparam int W = 480;
    localparam int R = 3;
    localparam int B = 5;
    localparam int D = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  result = 8'h00;
    logic        result_valid = 1'b0;
    logic        pixel_out_ready = 1'b0;
    logic [7:0]  pixel_out;
    logic        pixel_out_valid, sof, eol, eof, overflow;
    logic [10:0] fifo_level;
    logic [15:0] frame_count;
    int tests = 0;
    int fails = 0;

    result_stream_out #(.IMG_WIDTH(W), .OUT_ROWS(R), .BORDER_COLS(B), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .result(result), .result_valid(result_valid),
        .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid),
        .pixel_out_ready(pixel_out_ready), .sof(sof), .eol(eol), .eof(eof),
        .fifo_level(fifo_level), .overflow(overflow), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int col);
        return 8'(16 + col % 16);
    endfunction

    function automatic logic [7:0] exp_px(input int col);
        return (col >= W - B) ? 8'h00 : pat(col);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; result_valid = 1'b0; pixel_out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({pixel_out_valid, sof, eol, eof, overflow} !== 5'b0) begin
            fails++; $display("FAIL reset_flags: got %b expected 00000", {pixel_out_valid, sof, eol, eof, overflow});
        end
        tests++;
        if (pixel_out !== 8'h00 || fifo_level !== 11'd0 || frame_count !== 16'd0) begin
            fails++; $display("FAIL reset_values: px=%h lvl=%0d fc=%0d expected 0/0/0", pixel_out, fifo_level, frame_count);
        end
    endtask

    task automatic test_first_row();
        int wr = 0, got = 0, cyc = 0, first = -1, last = -1;
        do_reset();
        pixel_out_ready = 1'b1;
        do begin
            if (pixel_out_valid && first < 0) first = cyc;
            if (pixel_out_valid && pixel_out_ready) begin
                tests++;
                if (pixel_out !== exp_px(got % W)) begin
                    fails++; $display("FAIL row_pixel[%0d]: got %h expected %h", got, pixel_out, exp_px(got % W));
                end
                tests++;
                if ({sof, eol, eof} !== {got == 0, (got % W) == W - 1, 1'b0}) begin
                    fails++; $display("FAIL row_flags[%0d]: got %b expected %b", got, {sof, eol, eof}, {got == 0, (got % W) == W - 1, 1'b0});
                end
                got++; last = cyc;
            end
            result_valid = (wr < W); result = pat(wr % W);
            if (wr < W) wr++;
            step(); cyc++;
        end while (got < W && cyc < 3000);
        tests++;
        if (first !== 3) begin fails++; $display("FAIL latency: got %0d expected 3", first); end
        tests++;
        if (last !== 3 + W - 1) begin fails++; $display("FAIL row_throughput: last at %0d expected %0d", last, 3 + W - 1); end
        tests++;
        if (got !== W) begin fails++; $display("FAIL row_count: got %0d expected %0d", got, W); end
    endtask

    // Continues the raster from test_first_row through the end of frame.
    task automatic test_frame_eof();
        int wr = W, got = W, cyc = 0, eofs = 0, eof_at = -1, fc_cyc = -1;
        int n = R * W + 5;
        do begin
            if (cyc == fc_cyc - 1) begin
                tests++;
                if (frame_count !== 16'd0) begin fails++; $display("FAIL frame_count_early: got %0d expected 0", frame_count); end
            end
            if (cyc == fc_cyc) begin
                tests++;
                if (frame_count !== 16'd1) begin fails++; $display("FAIL frame_count: got %0d expected 1", frame_count); end
            end
            if (pixel_out_valid && pixel_out_ready) begin
                tests++;
                if (pixel_out !== exp_px(got % W) || sof !== ((got % (R * W)) == 0)) begin
                    fails++; $display("FAIL frame_pixel[%0d]: got %h sof=%b expected %h sof=%b", got, pixel_out, sof, exp_px(got % W), (got % (R * W)) == 0);
                end
                if (eof) begin eofs++; eof_at = got; fc_cyc = cyc + 2; end
                got++;
            end
            result_valid = (wr < n); result = pat(wr % W);
            if (wr < n) wr++;
            step(); cyc++;
        end while ((got < n || cyc <= fc_cyc) && cyc < 5000);
        tests++;
        if (eofs !== 1) begin fails++; $display("FAIL eof_count: got %0d expected 1", eofs); end
        tests++;
        if (eof_at !== R * W - 1) begin fails++; $display("FAIL eof_position: got %0d expected %0d", eof_at, R * W - 1); end
    endtask

    task automatic test_stall();
        int wr = 0, got = 0, cyc = 0, stall_left = 0;
        bit stalled = 0;
        logic [10:0] l0 = '0;
        logic [10:0] held = '0;
        do_reset();
        pixel_out_ready = 1'b1;
        do begin
            if (got == 100 && !stalled) begin
                stalled = 1; stall_left = 20; l0 = fifo_level;
                held = {pixel_out, sof, eol, eof};
            end else if (stall_left > 0) begin
                tests++;
                if ({pixel_out, sof, eol, eof} !== held || !pixel_out_valid) begin
                    fails++; $display("FAIL stall_hold: got %h expected %h", {pixel_out, sof, eol, eof}, held);
                end
                stall_left--;
                if (stall_left == 0) begin
                    tests++;
                    if (fifo_level !== l0 + 11'd20) begin
                        fails++; $display("FAIL stall_level: got %0d expected %0d", fifo_level, l0 + 11'd20);
                    end
                end
            end
            pixel_out_ready = (stall_left == 0);
            if (pixel_out_valid && pixel_out_ready) begin
                tests++;
                if (pixel_out !== exp_px(got % W)) begin
                    fails++; $display("FAIL stall_pixel[%0d]: got %h expected %h", got, pixel_out, exp_px(got % W));
                end
                got++;
            end
            result_valid = (wr < 200); result = pat(wr % W);
            if (wr < 200) wr++;
            step(); cyc++;
        end while (got < 200 && cyc < 1000);
        step(); step();
        tests++;
        if (got !== 200 || pixel_out_valid !== 1'b0 || fifo_level !== 11'd0) begin
            fails++; $display("FAIL stall_drain: got %0d valid=%b lvl=%0d expected 200/0/0", got, pixel_out_valid, fifo_level);
        end
    endtask

    task automatic test_overflow();
        int wr = 0, got = 0, cyc = 0, col = 0;
        logic [10:0] maxl = '0;
        do_reset();
        for (int i = 0; i < 1030; i++) begin
            result_valid = 1'b1; result = pat(i % W);
            step();
            if (fifo_level > maxl) maxl = fifo_level;
        end
        result_valid = 1'b0;
        step();
        tests++;
        if (fifo_level !== 11'd1024 || maxl !== 11'd1024) begin
            fails++; $display("FAIL overflow_level: got %0d max %0d expected 1024", fifo_level, maxl);
        end
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_flag: got %b expected 1", overflow); end
        wr = 1030;
        pixel_out_ready = 1'b1;
        do begin
            if (pixel_out_valid && pixel_out_ready) begin
                col = (got < 1026) ? got % W : (1030 + got - 1026) % W;
                tests++;
                if (pixel_out !== exp_px(col)) begin
                    fails++; $display("FAIL overflow_order[%0d]: got %h expected %h", got, pixel_out, exp_px(col));
                end
                got++;
            end
            result_valid = (got >= 1026 && wr < 1040); result = pat(wr % W);
            if (result_valid) wr++;
            step(); cyc++;
        end while (got < 1036 && cyc < 3000);
        tests++;
        if (got !== 1036 || overflow !== 1'b1) begin
            fails++; $display("FAIL overflow_drain: got %0d ovf=%b expected 1036/1", got, overflow);
        end
        pixel_out_ready = 1'b0;
        step(); step();
    endtask

    // Relies on test_overflow leaving overflow set and the pipeline empty.
    task automatic test_async_reset();
        int cyc = 0;
        bit seen = 0;
        for (int i = 0; i < 39; i++) begin
            result_valid = 1'b1; result = pat(i % 16);
            step();
        end
        result_valid = 1'b0;
        step(); step();
        tests++;
        if (fifo_level !== 11'd37 || pixel_out_valid !== 1'b1) begin
            fails++; $display("FAIL pre_reset: lvl=%0d valid=%b expected 37/1", fifo_level, pixel_out_valid);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({pixel_out_valid, sof, eol, eof, overflow} !== 5'b0 || pixel_out !== 8'h00 ||
            fifo_level !== 11'd0 || frame_count !== 16'd0) begin
            fails++; $display("FAIL async_reset: flags=%b px=%h lvl=%0d fc=%0d expected all 0",
                {pixel_out_valid, sof, eol, eof, overflow}, pixel_out, fifo_level, frame_count);
        end
        step();
        reset = 1'b0;
        pixel_out_ready = 1'b1;
        result_valid = 1'b1; result = pat(0);
        do begin
            if (pixel_out_valid && pixel_out_ready) seen = 1;
            else begin
                step(); cyc++;
                result_valid = 1'b0;
            end
        end while (!seen && cyc < 20);
        tests++;
        if (!seen || sof !== 1'b1 || pixel_out !== pat(0)) begin
            fails++; $display("FAIL post_reset_sof: seen=%b sof=%b px=%h expected 1/1/%h", seen, sof, pixel_out, pat(0));
        end
        step();
    endtask

    task automatic test_toggle();
        int wr = 0, got = 0, cyc = 0, t0 = 0, last = -1, eols = 0;
        bit started = 0;
        do_reset();
        do begin
            if (!started && pixel_out_valid) begin started = 1; t0 = cyc; end
            pixel_out_ready = started && (((cyc - t0) % 2) == 0);
            if (pixel_out_valid && pixel_out_ready) begin
                tests++;
                if (pixel_out !== exp_px(got % W) || eol !== ((got % W) == W - 1) || eof !== 1'b0) begin
                    fails++; $display("FAIL toggle_pixel[%0d]: got %h eol=%b eof=%b expected %h eol=%b eof=0",
                        got, pixel_out, eol, eof, exp_px(got % W), (got % W) == W - 1);
                end
                if (eol) eols++;
                got++; last = cyc - t0;
            end
            result_valid = (wr < 2 * W); result = pat(wr % W);
            if (wr < 2 * W) wr++;
            step(); cyc++;
        end while (got < 2 * W && cyc < 5000);
        tests++;
        if (last !== 2 * (2 * W - 1)) begin
            fails++; $display("FAIL toggle_throughput: last at %0d expected %0d", last, 2 * (2 * W - 1));
        end
        tests++;
        if (eols !== 2 || overflow !== 1'b0) begin
            fails++; $display("FAIL toggle_eol: eols=%0d ovf=%b expected 2/0", eols, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_first_row();
        test_frame_eof();
        test_stall();
        test_overflow();
        test_async_reset();
        test_toggle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
